pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the single-direction 32-bit left shifter in the execute stage.
- Supports four operations: SLL, SRL, SRA and ROR.
- Supports any power-of-two WIDTH, with an optional pipeline register after each shift level.
- Uses valid/ready handshakes, flush, and an opaque tag carried alongside each operation for the OoO issue/writeback path.

Parameters:
- WIDTH, 32: data width; must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived, not overridden.
- LEVELS, SHAMT_W: number of shift levels; derived.
- REG_MASK, {LEVELS{1'b1}}: bit k=1 places a register after level k. Level k shifts by 2^(LEVELS-1-k), so level 0 is the largest shift.
- TAG_W, 6: width of the ROB/physical-register tag passed through unchanged.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of every in-flight operation
- in_valid  in  1  input operation present
- in_ready  out  1  block can accept the input this cycle
- in_data  in  WIDTH  operand A
- in_shamt  in  SHAMT_W  shift amount
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock is clock. Reset is reset_n: asynchronous assert, active-low. On reset, all stage valid bits, out_valid, out_data and out_tag are 0.
- Shift order:
  - Levels are applied MSB-first: level k uses shamt bit LEVELS-1-k.
  - Each registered level also carries op, the remaining shamt bits, the tag and the sign bit.
- Per-operation fill:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with in_data[WIDTH-1], captured at entry and carried through every stage.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- Shift amount:
  - Shamt is interpreted as 0..WIDTH-1; there is no saturation.
  - Shamt 0 returns in_data unchanged for every op.
- Latency:
  - L = popcount(REG_MASK) cycles from accept to out_valid, with no stalls.
  - With L=0 the block is purely combinational: out_valid=in_valid, in_ready=out_ready, flush has no effect.
  - With L≥1, out_data and out_tag come directly from the final register. If REG_MASK bit LEVELS-1 is 0, trailing logic after the last register is allowed.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Register stage i advances when it is empty or stage i+1 advances; the last stage advances on out_ready.
  - in_ready equals stage-0 "can advance". It is combinational from out_ready through the chain; this is acceptable.
  - Throughput is one operation per cycle with out_ready held high. Bubbles are collapsed under backpressure: every register holds a valid op before any stall reaches the input.
  - Once out_valid is high, out_data and out_tag are held stable until the transfer or a flush.
  - While stalled, stage contents are held and must not change.
- Flush:
  - flush=1 clears all stage valids at the next edge.
  - An in_valid presented in the same cycle is discarded.
  - An output transfer in the flush cycle still counts as completed for the consumer.
  - in_ready is unaffected by flush.
- Reset mid-operation: all in-flight operations are dropped immediately, asynchronously; nothing is emitted after release.
- Data registers need no reset; valid bits and the output registers do.

Decomposition:
- Shared package/include shifter_defs:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - a WIDTH-to-SHAMT_W helper.
- One sub-module, shift_level:
  - parameters WIDTH, AMOUNT, REGISTERED, TAG_W.
  - performs one conditional shift by AMOUNT for all four ops.
  - contains an optional valid/ready register slice.
- The top level generates LEVELS instances of shift_level.

Test Plan:
- Defaults, SLL 0x0000_0001 shamt 31 -> 0x8000_0000 after 5 cycles with tag preserved; SRA 0x8000_0000 shamt 4 -> 0xF800_0000; SRL same inputs -> 0x0800_0000.
- ROR 0x1234_5678 shamt 8 -> 0x7812_3456; shamt 0 for all four ops -> input unchanged; WIDTH=8, REG_MASK=3'b000, ROR 0x81 shamt 1 -> 0xC0 in the same cycle.
- Back-to-back stream of 20 ops with out_ready=1 -> one result per cycle, in order, tags 0..19 matching.
- Hold out_ready=0 with 5 in flight -> in_ready drops once all 5 stages are full, out_data stable; release -> 5 results in order, none lost or duplicated.
- Assert flush with 3 in flight plus one new in_valid -> no out_valid next cycle; the next accepted op emerges correctly after L cycles.
- Drop reset_n mid-stream -> out_valid=0 asynchronously; after release, the first new op's result has the correct tag and data.

Source files
------------

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the helper that derives the shift-amount width from the data width.
package shifter_defs;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   function automatic int shamt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_level.sv
// One conditional shift level of the barrel shifter, shifting by AMOUNT when
// its shamt bit is set, followed by an optional valid/ready register slice.
module shift_level
   import shifter_defs::*;
#(
   parameter int WIDTH      = 32,
   parameter int AMOUNT     = 1,
   parameter bit REGISTERED = 1'b1,
   parameter int TAG_W      = 6,
   localparam int SHAMT_W   = shamt_width(WIDTH),
   localparam int SEL_BIT   = $clog2(AMOUNT)
)(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               in_sign,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SHAMT_W-1:0] out_shamt,
   output logic [1:0]         out_op,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_sign
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] fill_mask;

   // SRA fills with the sign captured at entry, not the current MSB, because
   // earlier levels may already have replaced the MSB.
   always_comb begin
      fill_mask = ~({WIDTH{1'b1}} >> AMOUNT);
      shifted   = in_data;
      if (in_shamt[SEL_BIT]) begin
         case (in_op)
            OP_SLL:  shifted = in_data << AMOUNT;
            OP_SRL:  shifted = in_data >> AMOUNT;
            OP_SRA:  shifted = (in_data >> AMOUNT) | (in_sign ? fill_mask : '0);
            default: shifted = (in_data >> AMOUNT) | (in_data << (WIDTH - AMOUNT));
         endcase
      end
   end

   if (REGISTERED) begin : g_reg
      logic               valid_q, valid_d;
      logic [WIDTH-1:0]   data_q, data_d;
      logic [SHAMT_W-1:0] shamt_q, shamt_d;
      logic [1:0]         op_q, op_d;
      logic [TAG_W-1:0]   tag_q, tag_d;
      logic               sign_q, sign_d;

      assign in_ready = !valid_q || out_ready;

      // Payload only loads on an accepted transfer so a stalled result stays put.
      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         shamt_d = shamt_q;
         op_d    = op_q;
         tag_d   = tag_q;
         sign_d  = sign_q;
         if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
               data_d  = shifted;
               shamt_d = in_shamt;
               op_d    = in_op;
               tag_d   = in_tag;
               sign_d  = in_sign;
            end
         end
         if (flush) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            sign_q  <= 1'b0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            sign_q  <= sign_d;
         end
      end

      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign out_shamt = shamt_q;
      assign out_op    = op_q;
      assign out_tag   = tag_q;
      assign out_sign  = sign_q;
   end else begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clock, reset_n, flush};

      assign in_ready  = out_ready;
      assign out_valid = in_valid;
      assign out_data  = shifted;
      assign out_shamt = in_shamt;
      assign out_op    = in_op;
      assign out_tag   = in_tag;
      assign out_sign  = in_sign;
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Parametrised SLL/SRL/SRA/ROR barrel shifter built from a chain of shift
// levels, largest shift first, with per-level optional pipeline registers.
module pipelined_barrel_shifter
   import shifter_defs::*;
#(
   parameter int                              WIDTH    = 32,
   parameter int                              TAG_W    = 6,
   parameter logic [shamt_width(WIDTH)-1:0]   REG_MASK = '1,
   localparam int                             SHAMT_W  = shamt_width(WIDTH),
   localparam int                             LEVELS   = SHAMT_W
)(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   // Each level owns its own link signals so the forward valid path and the
   // backward ready path stay distinct nets rather than one looping array.
   for (genvar k = 0; k < LEVELS; k++) begin : g_level
      logic               src_valid, src_sign, dst_ready;
      logic [WIDTH-1:0]   src_data;
      logic [SHAMT_W-1:0] src_shamt;
      logic [1:0]         src_op;
      logic [TAG_W-1:0]   src_tag;
      logic               lv_valid, lv_ready, lv_sign;
      logic [WIDTH-1:0]   lv_data;
      logic [SHAMT_W-1:0] lv_shamt;
      logic [1:0]         lv_op;
      logic [TAG_W-1:0]   lv_tag;

      if (k == 0) begin : g_head
         assign src_valid = in_valid;
         assign src_data  = in_data;
         assign src_shamt = in_shamt;
         assign src_op    = in_op;
         assign src_tag   = in_tag;
         assign src_sign  = in_data[WIDTH-1];
      end else begin : g_link
         assign src_valid = g_level[k-1].lv_valid;
         assign src_data  = g_level[k-1].lv_data;
         assign src_shamt = g_level[k-1].lv_shamt;
         assign src_op    = g_level[k-1].lv_op;
         assign src_tag   = g_level[k-1].lv_tag;
         assign src_sign  = g_level[k-1].lv_sign;
      end

      if (k == LEVELS - 1) begin : g_tail
         assign dst_ready = out_ready;
      end else begin : g_back
         assign dst_ready = g_level[k+1].lv_ready;
      end

      shift_level #(
         .WIDTH      (WIDTH),
         .AMOUNT     (1 << (LEVELS - 1 - k)),
         .REGISTERED (REG_MASK[k]),
         .TAG_W      (TAG_W)
      ) u_level (
         .clock     (clock),
         .reset_n   (reset_n),
         .flush     (flush),
         .in_valid  (src_valid),
         .in_ready  (lv_ready),
         .in_data   (src_data),
         .in_shamt  (src_shamt),
         .in_op     (src_op),
         .in_tag    (src_tag),
         .in_sign   (src_sign),
         .out_valid (lv_valid),
         .out_ready (dst_ready),
         .out_data  (lv_data),
         .out_shamt (lv_shamt),
         .out_op    (lv_op),
         .out_tag   (lv_tag),
         .out_sign  (lv_sign)
      );
   end

   logic unused_tail;
   assign unused_tail = ^{g_level[LEVELS-1].lv_shamt, g_level[LEVELS-1].lv_op,
                          g_level[LEVELS-1].lv_sign};

   assign in_ready  = g_level[0].lv_ready;
   assign out_valid = g_level[LEVELS-1].lv_valid;
   assign out_data  = g_level[LEVELS-1].lv_data;
   assign out_tag   = g_level[LEVELS-1].lv_tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: a fully registered 32-bit
// instance and a purely combinational 8-bit instance.
module tb_pipelined_barrel_shifter;
   import shifter_defs::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;
   logic [5:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_tag;

   logic        b_flush;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_data;
   logic [2:0]  b_in_shamt;
   logic [1:0]  b_in_op;
   logic [5:0]  b_in_tag;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [7:0]  b_out_data;
   logic [5:0]  b_out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pipelined_barrel_shifter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   pipelined_barrel_shifter #(.WIDTH(8), .REG_MASK(3'b000)) dut8 (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_shamt  (b_in_shamt),
      .in_op     (b_in_op),
      .in_tag    (b_in_tag),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_tag   (b_out_tag)
   );

   function automatic logic [31:0] refShift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
      logic [63:0] t;
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return 32'($signed(d) >>> s);
         default: begin
            t = {d, d} >> s;
            return t[31:0];
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [4:0] s,
                                input logic [1:0] op, input logic [5:0] tag);
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
      in_tag   = tag;
   endtask

   // One op through an empty pipe: absent after 4 edges, present after 5.
   task automatic runSingle(input string name, input logic [31:0] d, input logic [4:0] s,
                            input logic [1:0] op, input logic [5:0] tag,
                            input logic [31:0] expData);
      applyStimulus(1'b1, d, s, op, tag);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput({name, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clock);
      checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_data"}, out_data, expData);
      checkOutput({name, "_tag"}, 32'(out_tag), 32'(tag));
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  op;

      reset_n     = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      applyStimulus(1'b0, 32'd0, 5'd0, OP_SLL, 6'd0);
      b_flush     = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data   = 8'd0;
      b_in_shamt  = 3'd0;
      b_in_op     = OP_SLL;
      b_in_tag    = 6'd0;
      b_out_ready = 1'b1;

      #12;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", out_data, 32'd0);
      checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;

      runSingle("sll31", 32'h0000_0001, 5'd31, OP_SLL, 6'd21, 32'h8000_0000);
      runSingle("sra4", 32'h8000_0000, 5'd4, OP_SRA, 6'd22, 32'hF800_0000);
      runSingle("srl4", 32'h8000_0000, 5'd4, OP_SRL, 6'd23, 32'h0800_0000);
      runSingle("ror8", 32'h1234_5678, 5'd8, OP_ROR, 6'd24, 32'h7812_3456);
      runSingle("sll0", 32'hDEAD_BEEF, 5'd0, OP_SLL, 6'd25, 32'hDEAD_BEEF);
      runSingle("srl0", 32'hDEAD_BEEF, 5'd0, OP_SRL, 6'd26, 32'hDEAD_BEEF);
      runSingle("sra0", 32'hDEAD_BEEF, 5'd0, OP_SRA, 6'd27, 32'hDEAD_BEEF);
      runSingle("ror0", 32'hDEAD_BEEF, 5'd0, OP_ROR, 6'd28, 32'hDEAD_BEEF);
      runSingle("sra31", 32'h8000_0001, 5'd31, OP_SRA, 6'd29, 32'hFFFF_FFFF);
      runSingle("srl31", 32'hFFFF_FFFF, 5'd31, OP_SRL, 6'd30, 32'h0000_0001);
      runSingle("ror31", 32'h0000_0001, 5'd31, OP_ROR, 6'd31, 32'h0000_0002);
      runSingle("sra_pos", 32'h7000_0000, 5'd31, OP_SRA, 6'd32, 32'h0000_0000);

      // Combinational 8-bit instance
      b_in_valid = 1'b1;
      b_in_data  = 8'h81;
      b_in_shamt = 3'd1;
      b_in_op    = OP_ROR;
      b_in_tag   = 6'd7;
      #1;
      checkOutput("w8_ror_data", 32'(b_out_data), 32'h0000_00C0);
      checkOutput("w8_ror_valid", 32'(b_out_valid), 32'd1);
      checkOutput("w8_ror_tag", 32'(b_out_tag), 32'd7);
      checkOutput("w8_in_ready", 32'(b_in_ready), 32'd1);
      b_in_data  = 8'h90;
      b_in_shamt = 3'd3;
      b_in_op    = OP_SRA;
      b_flush    = 1'b1;
      b_out_ready = 1'b0;
      #1;
      checkOutput("w8_sra_data", 32'(b_out_data), 32'h0000_00F2);
      checkOutput("w8_flush_valid", 32'(b_out_valid), 32'd1);
      checkOutput("w8_in_ready_bp", 32'(b_in_ready), 32'd0);
      b_in_valid = 1'b0;
      #1;
      checkOutput("w8_valid_follow", 32'(b_out_valid), 32'd0);
      @(negedge clock);

      // Back-to-back stream of 20 ops
      for (int k = 0; k < 26; k++) begin
         if (k >= 5 && k < 25) begin
            d  = 32'h9E37_79B9 * 32'(k - 4);
            s  = 5'(((k - 5) * 7) % 32);
            op = 2'((k - 5) % 4);
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_tag", 32'(out_tag), 32'(k - 5));
            checkOutput("stream_data", out_data, refShift(d, s, op));
         end
         if (k == 25) begin
            checkOutput("stream_drained", 32'(out_valid), 32'd0);
         end
         if (k < 20) begin
            applyStimulus(1'b1, 32'h9E37_79B9 * 32'(k + 1), 5'((k * 7) % 32),
                          2'(k % 4), 6'(k));
         end else begin
            in_valid = 1'b0;
         end
         if (k < 25) @(negedge clock);
      end

      // Backpressure with five ops in flight
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checkOutput("bp_fill_ready", 32'(in_ready), 32'd1);
         applyStimulus(1'b1, 32'hA5A5_0000 | 32'(k), 5'(k + 1), 2'(k % 4), 6'(40 + k));
         @(negedge clock);
      end
      in_valid = 1'b0;
      checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_full_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_full_data", out_data, refShift(32'hA5A5_0000, 5'd1, 2'd0));
      repeat (2) @(negedge clock);
      checkOutput("bp_hold_data", out_data, refShift(32'hA5A5_0000, 5'd1, 2'd0));
      checkOutput("bp_hold_tag", 32'(out_tag), 32'd40);
      checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
      for (int k = 1; k < 5; k++) begin
         @(negedge clock);
         checkOutput("bp_drain_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_drain_tag", 32'(out_tag), 32'(40 + k));
         checkOutput("bp_drain_data", out_data,
                     refShift(32'hA5A5_0000 | 32'(k), 5'(k + 1), 2'(k % 4)));
      end
      @(negedge clock);
      checkOutput("bp_drain_empty", 32'(out_valid), 32'd0);

      // Flush with three in flight plus a new input
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 32'h1111_1111, 5'd1, OP_SLL, 6'(50 + k));
         @(negedge clock);
      end
      flush = 1'b1;
      applyStimulus(1'b1, 32'hFFFF_0000, 5'd4, OP_SRL, 6'd60);
      #1;
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      flush = 1'b0;
      checkOutput("flush_next_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 32'h0F0F_0F0F, 5'd4, OP_SLL, 6'd61);
      @(negedge clock);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput("flush_quiet", 32'(out_valid), 32'd0);
         @(negedge clock);
      end
      checkOutput("flush_after_valid", 32'(out_valid), 32'd1);
      checkOutput("flush_after_data", out_data, 32'hF0F0_F0F0);
      checkOutput("flush_after_tag", 32'(out_tag), 32'd61);
      @(negedge clock);

      // Reset mid-stream
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 32'h0000_00FF, 5'(k), OP_SLL, 6'(10 + k));
         @(negedge clock);
      end
      in_valid = 1'b0;
      checkOutput("rst_pre_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_async_data", out_data, 32'd0);
      checkOutput("rst_async_tag", 32'(out_tag), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      checkOutput("rst_release_valid", 32'(out_valid), 32'd0);
      runSingle("rst_first", 32'h8000_0001, 5'd31, OP_SRA, 6'd33, 32'hFFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
